// File: rtl/ysyx_24100012_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, access lengths,
// FSM state encoding and small decode helpers.
package ysyx_24100012_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam int LEN_B = 1;
    localparam int LEN_H = 2;
    localparam int LEN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    function automatic logic funct3_legal(input logic [2:0] f3);
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

    // Stores reuse the load encodings for size, so 100/101 act as byte/half.
    function automatic logic [2:0] len_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'(LEN_B);
            2'b01:   return 3'(LEN_H);
            default: return 3'(LEN_W);
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24100012_lsu_if.sv
// EXU-side request/response channel and data-memory channel of the LSU.
interface ysyx_24100012_lsu_req_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_fault;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

interface ysyx_24100012_lsu_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_ren;
    logic                  mem_wen;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_len;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_ren, mem_wen, mem_addr, mem_len, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_ren, mem_wen, mem_addr, mem_len, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/ysyx_24100012_lsu_ext.sv
// Load-data extender: picks the byte/half/word from right-justified memory
// data and sign- or zero-extends it according to funct3.
module ysyx_24100012_lsu_ext
    import ysyx_24100012_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] raw_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    always_comb begin
        data_o = raw_i;
        case (funct3_i)
            LB:      data_o = {{(DATA_WIDTH-8){raw_i[7]}}, raw_i[7:0]};
            LH:      data_o = {{(DATA_WIDTH-16){raw_i[15]}}, raw_i[15:0]};
            LBU:     data_o = {{(DATA_WIDTH-8){1'b0}}, raw_i[7:0]};
            LHU:     data_o = {{(DATA_WIDTH-16){1'b0}}, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/ysyx_24100012_lsu.sv
// Load/store unit: accepts one EXU access, checks alignment, runs a single
// memory handshake with a timeout and returns a one-cycle response.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | mem_valid held until the memory accepts
// WAIT  | accepted, waiting for mem_rvalid
// RESP  | one-cycle resp_valid pulse
module ysyx_24100012_lsu
    import ysyx_24100012_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ysyx_24100012_lsu_req_if.slave   req,
    ysyx_24100012_lsu_mem_if.master  mem
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    lsu_state_e            state_q, state_d;
    logic                  store_q, store_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  fault_q, fault_d;
    logic [15:0]           cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] ext_data;
    logic [DATA_WIDTH-1:0] wdata_masked;
    logic [2:0]            len_bytes;
    logic                  timed_out;

    ysyx_24100012_lsu_ext #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ext (
        .funct3_i (funct3_q),
        .raw_i    (mem.mem_rdata),
        .data_o   (ext_data)
    );

    assign len_bytes = len_of(funct3_q);
    assign timed_out = (cnt_q + 16'd1) == TIMEOUT_CNT;

    always_comb begin
        wdata_masked = wdata_q;
        case (len_bytes)
            3'd1:    wdata_masked = DATA_WIDTH'(wdata_q[7:0]);
            3'd2:    wdata_masked = DATA_WIDTH'(wdata_q[15:0]);
            default: wdata_masked = wdata_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;

        req.req_ready  = 1'b0;
        req.resp_valid = 1'b0;
        req.resp_fault = 1'b0;
        req.resp_rdata = '0;
        mem.mem_valid  = 1'b0;
        mem.mem_ren    = 1'b0;
        mem.mem_wen    = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_len    = '0;
        mem.mem_wdata  = '0;

        case (state_q)
            ST_IDLE: begin
                req.req_ready = 1'b1;
                if (req.req_valid) begin
                    store_d  = req.req_store;
                    funct3_d = req.req_funct3;
                    addr_d   = req.req_addr;
                    wdata_d  = req.req_wdata;
                    cnt_d    = '0;
                    rdata_d  = '0;
                    if (!funct3_legal(req.req_funct3) ||
                        misaligned(req.req_funct3, req.req_addr[1:0])) begin
                        fault_d = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        fault_d = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                mem.mem_valid = 1'b1;
                mem.mem_ren   = !store_q;
                mem.mem_wen   = store_q;
                mem.mem_addr  = addr_q;
                mem.mem_len   = DATA_WIDTH'(len_bytes);
                mem.mem_wdata = wdata_masked;
                cnt_d         = cnt_q + 16'd1;
                // Completion beats timeout, timeout beats a bare accept.
                if (mem.mem_ready && mem.mem_rvalid) begin
                    rdata_d = store_q ? '0 : ext_data;
                    fault_d = 1'b0;
                    state_d = ST_RESP;
                end else if (timed_out) begin
                    rdata_d = '0;
                    fault_d = 1'b1;
                    state_d = ST_RESP;
                end else if (mem.mem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (mem.mem_rvalid) begin
                    rdata_d = store_q ? '0 : ext_data;
                    fault_d = 1'b0;
                    state_d = ST_RESP;
                end else if (timed_out) begin
                    rdata_d = '0;
                    fault_d = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                req.resp_valid = 1'b1;
                req.resp_fault = fault_q;
                req.resp_rdata = rdata_q;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            store_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24100012_lsu.sv
// Self-checking bench for the LSU: transaction-level model of latency,
// faults, extension and memory-side signalling, with directed and random cases.
module tb_ysyx_24100012_lsu;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_24100012_lsu_req_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) req_if ();
    ysyx_24100012_lsu_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    ysyx_24100012_lsu #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_if),
        .mem   (mem_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference rules written as plain arithmetic on the access size.
    function automatic int m_size(input int f3);
        if ((f3 % 4) == 0) return 1;
        if ((f3 % 4) == 1) return 2;
        return 4;
    endfunction

    function automatic bit m_fault(input int f3, input logic [31:0] addr);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        return (addr % m_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input int f3, input logic [31:0] raw);
        int v;
        case (f3)
            0: begin v = int'(raw % 256);   if (v > 127)   v -= 256;   return 32'(v); end
            1: begin v = int'(raw % 65536); if (v > 32767) v -= 65536; return 32'(v); end
            4: return raw % 256;
            5: return raw % 65536;
            default: return raw;
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_req_ready", 32'(req_if.req_ready), 32'd1);
            chk("idle_resp_valid", 32'(req_if.resp_valid), 32'd0);
            chk("idle_mem_valid", 32'(mem_if.mem_valid), 32'd0);
            req_if.req_valid   = 1'b0;
            mem_if.mem_ready   = 1'($urandom % 2);
            mem_if.mem_rvalid  = 1'($urandom % 2);
            mem_if.mem_rdata   = $urandom;
        end
    endtask

    // rw = cycles mem_ready is held low; rvd = cycles from accept to rvalid (-1 never).
    task automatic do_txn(input bit st, input int f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int rw, input int rvd,
                          input logic [31:0] raw,
                          output logic [31:0] o_rdata, output bit o_fault,
                          output int o_lat, output int o_issue, output logic [31:0] o_wdata);
        bit flt, to_flt, in_iss;
        int t, resp_k, iss_end, sz;
        logic [31:0] exp_rd, exp_wd;
        flt     = m_fault(f3, addr);
        sz      = m_size(f3);
        t       = (rvd < 0) ? 1000 : rw + 1 + rvd;
        to_flt  = !flt && (t > TO);
        resp_k  = flt ? 1 : 1 + ((t <= TO) ? t : TO);
        iss_end = flt ? 0 : (((rw + 1) < (resp_k - 1)) ? rw + 1 : resp_k - 1);
        exp_rd  = (flt || to_flt || st) ? 32'h0 : m_load(f3, raw);
        exp_wd  = (sz == 4) ? wdata : wdata % (32'd1 << (8 * sz));
        o_rdata = '0; o_fault = 1'b0; o_lat = -1; o_issue = 0; o_wdata = '0;

        @(negedge clk);
        chk("accept_req_ready", 32'(req_if.req_ready), 32'd1);
        req_if.req_valid  = 1'b1;
        req_if.req_store  = st;
        req_if.req_funct3 = 3'(f3);
        req_if.req_addr   = addr;
        req_if.req_wdata  = wdata;
        mem_if.mem_ready  = 1'b0;
        mem_if.mem_rvalid = 1'($urandom % 2);
        mem_if.mem_rdata  = $urandom;

        for (int k = 1; k <= resp_k; k++) begin
            @(negedge clk);
            req_if.req_valid  = 1'b0;
            req_if.req_store  = 1'($urandom % 2);
            req_if.req_funct3 = 3'($urandom % 8);
            req_if.req_addr   = $urandom;
            req_if.req_wdata  = $urandom;
            in_iss = (k <= iss_end);
            chk("mem_valid", 32'(mem_if.mem_valid), 32'(in_iss));
            chk("mem_ren", 32'(mem_if.mem_ren), 32'(in_iss && !st));
            chk("mem_wen", 32'(mem_if.mem_wen), 32'(in_iss && st));
            if (in_iss) begin
                o_issue++;
                chk("mem_addr", mem_if.mem_addr, addr);
                chk("mem_len", mem_if.mem_len, 32'(sz));
                if (st) begin
                    chk("mem_wdata", mem_if.mem_wdata, exp_wd);
                    o_wdata = mem_if.mem_wdata;
                end
            end
            chk("busy_req_ready", 32'(req_if.req_ready), 32'd0);
            chk("resp_valid", 32'(req_if.resp_valid), 32'(k == resp_k));
            if (k == resp_k) begin
                chk("resp_fault", 32'(req_if.resp_fault), 32'(flt || to_flt));
                chk("resp_rdata", req_if.resp_rdata, exp_rd);
                o_rdata = req_if.resp_rdata;
                o_fault = req_if.resp_fault;
                o_lat   = k;
            end
            mem_if.mem_ready = in_iss && (k == rw + 1);
            if (!flt && !to_flt && k == t) begin
                mem_if.mem_rvalid = 1'b1;
                mem_if.mem_rdata  = raw;
            end else begin
                mem_if.mem_rvalid = (k == resp_k) ? 1'($urandom % 2) : 1'b0;
                mem_if.mem_rdata  = $urandom;
            end
        end
    endtask

    logic [31:0] r_rdata, r_wdata;
    bit          r_fault;
    int          r_lat, r_issue;

    initial begin
        req_if.req_valid  = 1'b0;
        req_if.req_store  = 1'b0;
        req_if.req_funct3 = 3'b0;
        req_if.req_addr   = '0;
        req_if.req_wdata  = '0;
        mem_if.mem_ready  = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata  = '0;

        @(negedge clk);
        chk("rst_req_ready", 32'(req_if.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(req_if.resp_valid), 32'd0);
        chk("rst_resp_fault", 32'(req_if.resp_fault), 32'd0);
        chk("rst_resp_rdata", req_if.resp_rdata, 32'd0);
        chk("rst_mem_valid", 32'(mem_if.mem_valid), 32'd0);
        chk("rst_mem_ren", 32'(mem_if.mem_ren), 32'd0);
        chk("rst_mem_wen", 32'(mem_if.mem_wen), 32'd0);
        chk("rst_mem_addr", mem_if.mem_addr, 32'd0);
        chk("rst_mem_len", mem_if.mem_len, 32'd0);
        chk("rst_mem_wdata", mem_if.mem_wdata, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Aligned lw, one-cycle memory latency.
        do_txn(1'b0, 2, 32'h8000_0004, 32'h0, 0, 1, 32'hDEAD_BEEF, r_rdata, r_fault, r_lat, r_issue, r_wdata);
        chk("lw_rdata_lit", r_rdata, 32'hDEAD_BEEF);
        chk("lw_lat_lit", 32'(r_lat), 32'd3);
        idle(1);

        do_txn(1'b0, 0, 32'h8000_0001, 32'h0, 0, 1, 32'h0000_0080, r_rdata, r_fault, r_lat, r_issue, r_wdata);
        chk("lb_rdata_lit", r_rdata, 32'hFFFF_FF80);
        do_txn(1'b0, 4, 32'h8000_0001, 32'h0, 0, 1, 32'h0000_0080, r_rdata, r_fault, r_lat, r_issue, r_wdata);
        chk("lbu_rdata_lit", r_rdata, 32'h0000_0080);
        do_txn(1'b0, 1, 32'h8000_0002, 32'h0, 1, 2, 32'h1234_8001, r_rdata, r_fault, r_lat, r_issue, r_wdata);
        chk("lh_rdata_lit", r_rdata, 32'hFFFF_8001);

        // sh with mem_ready held low for three cycles.
        do_txn(1'b1, 1, 32'h8000_0002, 32'h1234_5678, 3, 1, 32'hFFFF_FFFF, r_rdata, r_fault, r_lat, r_issue, r_wdata);
        chk("sh_wdata_lit", r_wdata, 32'h0000_5678);
        chk("sh_issue_cycles_lit", 32'(r_issue), 32'd4);
        chk("sh_rdata_lit", r_rdata, 32'h0);

        // Misaligned lw never touches memory.
        do_txn(1'b0, 2, 32'h8000_0002, 32'h0, 0, 1, 32'h1, r_rdata, r_fault, r_lat, r_issue, r_wdata);
        chk("mis_fault_lit", 32'(r_fault), 32'd1);
        chk("mis_lat_lit", 32'(r_lat), 32'd1);
        chk("mis_issue_lit", 32'(r_issue), 32'd0);

        // Timeout: accepted but no completion, and never accepted.
        do_txn(1'b0, 2, 32'h8000_0008, 32'h0, 0, -1, 32'h0, r_rdata, r_fault, r_lat, r_issue, r_wdata);
        chk("to_fault_lit", 32'(r_fault), 32'd1);
        chk("to_lat_lit", 32'(r_lat), 32'd9);
        idle(1);
        do_txn(1'b1, 2, 32'h8000_000C, 32'hCAFE_F00D, 12, 1, 32'h0, r_rdata, r_fault, r_lat, r_issue, r_wdata);
        chk("to_issue_lit", 32'(r_issue), 32'd8);

        // Completion in the accept cycle, and completion on the timeout cycle.
        do_txn(1'b0, 5, 32'h8000_0006, 32'h0, 0, 0, 32'h0000_9ABC, r_rdata, r_fault, r_lat, r_issue, r_wdata);
        chk("same_cycle_lat_lit", 32'(r_lat), 32'd2);
        chk("lhu_rdata_lit", r_rdata, 32'h0000_9ABC);
        do_txn(1'b0, 2, 32'h8000_0010, 32'h0, 2, 5, 32'h0BAD_CAFE, r_rdata, r_fault, r_lat, r_issue, r_wdata);
        chk("edge_fault_lit", 32'(r_fault), 32'd0);
        chk("edge_rdata_lit", r_rdata, 32'h0BAD_CAFE);

        // Reset asserted while waiting for completion.
        @(negedge clk);
        req_if.req_valid  = 1'b1;
        req_if.req_store  = 1'b0;
        req_if.req_funct3 = 3'b010;
        req_if.req_addr   = 32'h8000_0020;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        mem_if.mem_ready = 1'b1;
        mem_if.mem_rvalid = 1'b0;
        @(negedge clk);
        chk("rw_wait_mem_valid", 32'(mem_if.mem_valid), 32'd0);
        chk("rw_wait_req_ready", 32'(req_if.req_ready), 32'd0);
        mem_if.mem_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rw_req_ready", 32'(req_if.req_ready), 32'd1);
        chk("rw_resp_valid", 32'(req_if.resp_valid), 32'd0);
        chk("rw_resp_rdata", req_if.resp_rdata, 32'd0);
        chk("rw_mem_valid", 32'(mem_if.mem_valid), 32'd0);
        chk("rw_mem_addr", mem_if.mem_addr, 32'd0);
        chk("rw_mem_len", mem_if.mem_len, 32'd0);
        mem_if.mem_rvalid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        do_txn(1'b0, 2, 32'h8000_0024, 32'h0, 0, 1, 32'h5555_AAAA, r_rdata, r_fault, r_lat, r_issue, r_wdata);
        chk("post_rst_rdata_lit", r_rdata, 32'h5555_AAAA);

        for (int n = 0; n < 60; n++) begin
            bit          st;
            int          f3, rw, rvd;
            logic [31:0] addr;
            st   = 1'($urandom % 2);
            f3   = int'($urandom % 8);
            addr = $urandom;
            if ($urandom % 4 != 0) addr[1:0] = 2'b00;
            rw   = ($urandom % 6 == 0) ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 2));
            rvd  = ($urandom % 8 == 0) ? -1 : int'($urandom_range(0, 4));
            do_txn(st, f3, addr, $urandom, rw, rvd, $urandom, r_rdata, r_fault, r_lat, r_issue, r_wdata);
            idle(int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
